wishbone_arbiter: RTL and testbench
===================================

// Module: wishbone_arbiter
//
// PURPOSE
// Two-master, one-slave Wishbone classic arbiter that shares the memory bus between the
// core's bus interface (master 0) and a second requester (master 1, e.g. DMA or debug).
// Round-robin arbitration, with the grant held for the whole CYC.
// A bus-timeout watchdog turns a hung slave into an error to the granted master.
// Sits between the core/peripheral masters and the memory/peripheral interconnect.
//
// PARAMETERS
// DATA_SIZE  32   data bus width; byte selects are DATA_SIZE/8 bits wide
// ADDR_SIZE  32   address width
// TIMEOUT    255  cycles of STB without ACK before an error; 0 disables the watchdog
//
// PORTS
// clock           in   1            system clock, rising edge
// reset           in   1            asynchronous, active-low reset
// m{0,1}_CYC_I    in   1            master cycle request
// m{0,1}_STB_I    in   1            master strobe
// m{0,1}_WE_I     in   1            master write enable
// m{0,1}_SEL_I    in   DATA_SIZE/8  master byte selects
// m{0,1}_ADR_I    in   ADDR_SIZE    master address
// m{0,1}_DAT_I    in   DATA_SIZE    master write data
// m{0,1}_DAT_O    out  DATA_SIZE    read data to master
// m{0,1}_ACK_O    out  1            ack to master (granted master only)
// m{0,1}_ERR_O    out  1            timeout error to master, one-cycle pulse
// s_CYC_O/STB_O/WE_O  out  1        slave cycle, strobe and write enable
// s_SEL_O         out  DATA_SIZE/8  slave byte selects
// s_ADR_O         out  ADDR_SIZE    slave address
// s_DAT_O         out  DATA_SIZE    slave write data
// s_DAT_I         in   DATA_SIZE    slave read data
// s_ACK_I         in   1            slave ack
// grant           out  2            one-hot current owner {m1,m0}; 00 when idle
//
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, last=1, timer=0.
//   All s_* outputs, ACK_O, ERR_O and grant = 0. Applies mid-transaction; no ack is delivered.
// - States: IDLE, GNT0, GNT1, ERRW.
// - IDLE
//   - Only mX_CYC_I high -> GNTX next edge.
//   - Both high -> grant the master != last.
//   - Neither high -> stay in IDLE.
//   - Arbitration latency is one cycle; s_* outputs are all 0 in IDLE.
// - GNTX
//   - s_CYC/STB/WE/SEL/ADR/DAT_O are combinationally muxed from master X, gated by the state.
//   - mX_ACK_O = s_ACK_I.
//   - The other master's ACK_O/ERR_O = 0.
//   - Both m*_DAT_O = s_DAT_I.
//   - On entry, last <= X.
// - Release
//   - In GNTX with mX_CYC_I=0 -> IDLE. No preemption while CYC is held.
//   - A waiting master is therefore granted 2 cycles after release: IDLE, then GNT.
// - Watchdog (TIMEOUT>0)
//   - timer increments each cycle in GNTX with s_STB_O=1 and s_ACK_I=0.
//   - timer clears on s_ACK_I, on leaving GNTX, and when STB=0.
//   - timer==TIMEOUT-1 with no ack:
//     - mX_ERR_O=1 for that cycle.
//     - s_CYC_O and s_STB_O are forced to 0 in that same cycle.
//     - Next state is ERRW.
// - ERRW
//   - s_* outputs are 0, grant stays X, ACK_O/ERR_O are 0.
//   - Exits to IDLE once mX_CYC_I=0.
// - Simultaneous ack and expiry: ack wins. ERR is not raised and timer clears.
// - ACK_O and ERR_O are never both high; at most one master sees ACK or ERR in any cycle.
// - timer is wide enough for TIMEOUT and saturates; there is no wrap-around.
//
// TESTING
// - Reset then idle.
//   - Stimulus: reset low, both CYC=0.
//   - Required: all outputs 0, grant=00.
//   - Stimulus: release reset with m0 asserting CYC/STB, ADR=0x100.
//   - Required: next cycle grant=01, s_ADR_O=0x100; ACK from the slave after 2 cycles reaches only m0_ACK_O.
// - Contention and round-robin.
//   - Stimulus: m0 and m1 raise CYC in the same cycle.
//   - Required: grant=01 first (last=1 after reset).
//   - Stimulus: after m0 drops CYC.
//   - Required: IDLE for one cycle, then grant=10.
//   - Stimulus: a repeated tie.
//   - Required: m0 is granted.
// - Hold.
//   - Stimulus: m0 holds CYC over 3 ack'd beats while m1 requests.
//   - Required: m1 is not granted until m0 drops CYC; m1_ACK_O=0 throughout.
// - Timeout.
//   - Stimulus: TIMEOUT=4, slave never acks.
//   - Required: m1_ERR_O pulses on the 4th STB cycle; s_CYC_O=0 from that cycle; IDLE after m1 drops CYC.
//   - Stimulus: ack arriving in that same 4th cycle.
//   - Required: ACK is delivered and no ERR.
// - Async reset mid-cycle.
//   - Stimulus: assert reset during GNT1 with STB high.
//   - Required: s_CYC_O, s_STB_O and grant go to 0 without waiting for a clock edge.
//   - Stimulus: release reset, then re-request.
//   - Required: arbitration restarts from IDLE.

Source files
------------

// File: rtl/wishbone_arbiter.sv
// Two-master, one-slave Wishbone classic arbiter.
// Round-robin arbitration with the grant held for the whole CYC. A bus watchdog
// converts a slave that never acks into a one-cycle error pulse to the owner.
module wishbone_arbiter #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   m0_CYC_I,
  input  logic                   m0_STB_I,
  input  logic                   m0_WE_I,
  input  logic [DATA_SIZE/8-1:0] m0_SEL_I,
  input  logic [ADDR_SIZE-1:0]   m0_ADR_I,
  input  logic [DATA_SIZE-1:0]   m0_DAT_I,
  output logic [DATA_SIZE-1:0]   m0_DAT_O,
  output logic                   m0_ACK_O,
  output logic                   m0_ERR_O,

  input  logic                   m1_CYC_I,
  input  logic                   m1_STB_I,
  input  logic                   m1_WE_I,
  input  logic [DATA_SIZE/8-1:0] m1_SEL_I,
  input  logic [ADDR_SIZE-1:0]   m1_ADR_I,
  input  logic [DATA_SIZE-1:0]   m1_DAT_I,
  output logic [DATA_SIZE-1:0]   m1_DAT_O,
  output logic                   m1_ACK_O,
  output logic                   m1_ERR_O,

  output logic                   s_CYC_O,
  output logic                   s_STB_O,
  output logic                   s_WE_O,
  output logic [DATA_SIZE/8-1:0] s_SEL_O,
  output logic [ADDR_SIZE-1:0]   s_ADR_O,
  output logic [DATA_SIZE-1:0]   s_DAT_O,
  input  logic [DATA_SIZE-1:0]   s_DAT_I,
  input  logic                   s_ACK_I,

  output logic [1:0]             grant
);

  localparam int SEL_SIZE = DATA_SIZE / 8;
  // Timer holds values up to TIMEOUT; at least one bit so the vector is legal.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    ERRW = 2'd3
  } state_t;

  state_t          state, state_next;
  logic            last, last_next;
  logic [TW-1:0]   timer, timer_next;

  logic                 in_gnt;
  logic                 own_cyc;
  logic                 own_stb;
  logic                 own_we;
  logic [SEL_SIZE-1:0]  own_sel;
  logic [ADDR_SIZE-1:0] own_adr;
  logic [DATA_SIZE-1:0] own_dat;
  logic                 last_cyc;
  logic                 stalled;
  logic                 expire;

  // Read data is broadcast; only the owner's ACK qualifies it.
  assign m0_DAT_O = s_DAT_I;
  assign m1_DAT_O = s_DAT_I;

  // Select the owning master's request signals; GNT1 picks master 1.
  always_comb begin
    in_gnt  = (state == GNT0) || (state == GNT1);
    own_cyc = m0_CYC_I;
    own_stb = m0_STB_I;
    own_we  = m0_WE_I;
    own_sel = m0_SEL_I;
    own_adr = m0_ADR_I;
    own_dat = m0_DAT_I;
    if (state == GNT1) begin
      own_cyc = m1_CYC_I;
      own_stb = m1_STB_I;
      own_we  = m1_WE_I;
      own_sel = m1_SEL_I;
      own_adr = m1_ADR_I;
      own_dat = m1_DAT_I;
    end
    last_cyc = last ? m1_CYC_I : m0_CYC_I;
    stalled  = in_gnt && own_cyc && own_stb && !s_ACK_I;
    expire   = (TIMEOUT > 0) && stalled && (timer == LIMIT);
  end

  // State, round-robin pointer and watchdog timer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b1;
      timer <= '0;
    end else begin
      state <= state_next;
      last  <= last_next;
      timer <= timer_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, hold while CYC, park in ERRW after a timeout.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (m0_CYC_I && m1_CYC_I) begin
          state_next = last ? GNT0 : GNT1;
        end else if (m0_CYC_I) begin
          state_next = GNT0;
        end else if (m1_CYC_I) begin
          state_next = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!own_cyc) begin
          state_next = IDLE;
        end else if (expire) begin
          state_next = ERRW;
        end
      end
      ERRW: begin
        if (!last_cyc) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state == IDLE && state_next == GNT0) begin
      last_next = 1'b0;
    end else if (state == IDLE && state_next == GNT1) begin
      last_next = 1'b1;
    end
  end

  // Watchdog counts stalled strobe cycles; any ack, idle strobe or expiry clears it.
  always_comb begin
    timer_next = '0;
    if ((TIMEOUT > 0) && stalled && !expire) begin
      timer_next = (timer == TMAX) ? timer : timer + TW'(1);
    end
  end

  // Slave-side mux and master responses, all gated by the current state.
  always_comb begin
    s_CYC_O  = 1'b0;
    s_STB_O  = 1'b0;
    s_WE_O   = 1'b0;
    s_SEL_O  = '0;
    s_ADR_O  = '0;
    s_DAT_O  = '0;
    m0_ACK_O = 1'b0;
    m1_ACK_O = 1'b0;
    m0_ERR_O = 1'b0;
    m1_ERR_O = 1'b0;
    grant    = 2'b00;
    case (state)
      GNT0, GNT1: begin
        s_CYC_O = own_cyc && !expire;
        s_STB_O = own_stb && !expire;
        s_WE_O  = own_we;
        s_SEL_O = own_sel;
        s_ADR_O = own_adr;
        s_DAT_O = own_dat;
        if (state == GNT0) begin
          grant    = 2'b01;
          m0_ACK_O = s_ACK_I;
          m0_ERR_O = expire;
        end else begin
          grant    = 2'b10;
          m1_ACK_O = s_ACK_I;
          m1_ERR_O = expire;
        end
      end
      ERRW: begin
        grant = last ? 2'b10 : 2'b01;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Self-checking bench for wishbone_arbiter with a short watchdog (TIMEOUT=4).
// Acked reads are predicted into a scoreboard and checked when an ACK appears.
module tb_wishbone_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam logic [31:0] DKEY = 32'hA5A5_0000;

  logic          clock;
  logic          reset;
  logic          m0_CYC_I, m0_STB_I, m0_WE_I;
  logic [3:0]    m0_SEL_I;
  logic [AW-1:0] m0_ADR_I;
  logic [DW-1:0] m0_DAT_I, m0_DAT_O;
  logic          m0_ACK_O, m0_ERR_O;
  logic          m1_CYC_I, m1_STB_I, m1_WE_I;
  logic [3:0]    m1_SEL_I;
  logic [AW-1:0] m1_ADR_I;
  logic [DW-1:0] m1_DAT_I, m1_DAT_O;
  logic          m1_ACK_O, m1_ERR_O;
  logic          s_CYC_O, s_STB_O, s_WE_O;
  logic [3:0]    s_SEL_O;
  logic [AW-1:0] s_ADR_O;
  logic [DW-1:0] s_DAT_O, s_DAT_I;
  logic          s_ACK_I;
  logic [1:0]    grant;

  int checkCount;
  int failCount;
  logic [32:0] expQueue[$];

  wishbone_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .m0_CYC_I(m0_CYC_I), .m0_STB_I(m0_STB_I), .m0_WE_I(m0_WE_I), .m0_SEL_I(m0_SEL_I),
    .m0_ADR_I(m0_ADR_I), .m0_DAT_I(m0_DAT_I), .m0_DAT_O(m0_DAT_O),
    .m0_ACK_O(m0_ACK_O), .m0_ERR_O(m0_ERR_O),
    .m1_CYC_I(m1_CYC_I), .m1_STB_I(m1_STB_I), .m1_WE_I(m1_WE_I), .m1_SEL_I(m1_SEL_I),
    .m1_ADR_I(m1_ADR_I), .m1_DAT_I(m1_DAT_I), .m1_DAT_O(m1_DAT_O),
    .m1_ACK_O(m1_ACK_O), .m1_ERR_O(m1_ERR_O),
    .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O), .s_WE_O(s_WE_O), .s_SEL_O(s_SEL_O),
    .s_ADR_O(s_ADR_O), .s_DAT_O(s_DAT_O), .s_DAT_I(s_DAT_I), .s_ACK_I(s_ACK_I),
    .grant(grant)
  );

  // Slave model returns data derived from the address it sees.
  assign s_DAT_I = s_ADR_O ^ DKEY;

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic cyc, input logic stb,
                               input logic we, input logic [AW-1:0] adr);
    if (m == 0) begin
      m0_CYC_I = cyc; m0_STB_I = stb; m0_WE_I = we; m0_ADR_I = adr;
      m0_SEL_I = 4'hF; m0_DAT_I = ~adr;
    end else begin
      m1_CYC_I = cyc; m1_STB_I = stb; m1_WE_I = we; m1_ADR_I = adr;
      m1_SEL_I = 4'hF; m1_DAT_I = ~adr;
    end
  endtask

  task automatic expectAck(input logic id, input logic [AW-1:0] adr);
    expQueue.push_back({id, adr ^ DKEY});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  // Scoreboard: every ACK must match the oldest predicted master and read data.
  always @(negedge clock) begin
    if (reset && (m0_ACK_O || m1_ACK_O)) begin
      checkOutput("resp_exclusive",
                  64'(m0_ACK_O) + 64'(m1_ACK_O) + 64'(m0_ERR_O) + 64'(m1_ERR_O), 64'd1);
      if (expQueue.size() == 0) begin
        checkOutput("sb_unexpected_ack", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        e = expQueue.pop_front();
        checkOutput("sb_ack_master", 64'(m1_ACK_O), 64'(e[32]));
        checkOutput("sb_read_data", 64'(e[32] ? m1_DAT_O : m0_DAT_O), 64'(e[31:0]));
      end
    end
  end

  initial begin
    checkCount = 0;
    failCount  = 0;
    reset = 1'b0;
    s_ACK_I = 1'b1;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0);

    // Reset state: everything quiet even with the slave acking.
    repeat (2) @(posedge clock);
    sample();
    checkOutput("rst_grant", 64'(grant), 64'd0);
    checkOutput("rst_s_cyc", 64'(s_CYC_O), 64'd0);
    checkOutput("rst_s_stb", 64'(s_STB_O), 64'd0);
    checkOutput("rst_acks", 64'({m0_ACK_O, m1_ACK_O}), 64'd0);
    checkOutput("rst_errs", 64'({m0_ERR_O, m1_ERR_O}), 64'd0);

    // First transaction from m0 after reset release.
    step();
    reset = 1'b1;
    s_ACK_I = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h100);
    sample();
    checkOutput("arb_latency_idle", 64'(grant), 64'd0);
    step(); sample();
    checkOutput("first_grant", 64'(grant), 64'd1);
    checkOutput("first_adr", 64'(s_ADR_O), 64'h100);
    checkOutput("first_cyc", 64'(s_CYC_O), 64'd1);
    step(); sample();
    checkOutput("first_wait_ack", 64'(m0_ACK_O), 64'd0);
    step();
    s_ACK_I = 1'b1;
    expectAck(1'b0, 32'h100);
    sample();
    checkOutput("first_m1_noack", 64'(m1_ACK_O), 64'd0);
    step();
    s_ACK_I = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0);
    step(); sample();
    checkOutput("first_release", 64'(grant), 64'd0);

    // Fresh reset so last=1, then a simultaneous request.
    step();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h200);
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h300);
    step(); sample();
    checkOutput("tie_grant_m0", 64'(grant), 64'd1);
    checkOutput("tie_adr_m0", 64'(s_ADR_O), 64'h200);

    // m0 holds CYC across three acked beats while m1 waits.
    for (int b = 0; b < 3; b++) begin
      step();
      applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(b * 4));
      s_ACK_I = 1'b1;
      expectAck(1'b0, 32'h200 + 32'(b * 4));
      sample();
      checkOutput("hold_grant", 64'(grant), 64'd1);
      checkOutput("hold_m1_ack", 64'(m1_ACK_O), 64'd0);
      step();
      s_ACK_I = 1'b0;
      sample();
      checkOutput("hold_grant_gap", 64'(grant), 64'd1);
    end
    step();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0);
    step(); sample();
    checkOutput("release_idle", 64'(grant), 64'd0);
    step(); sample();
    checkOutput("rr_grant_m1", 64'(grant), 64'd2);
    checkOutput("rr_adr_m1", 64'(s_ADR_O), 64'h300);
    step();
    s_ACK_I = 1'b1;
    expectAck(1'b1, 32'h300);
    sample();
    checkOutput("rr_m0_noack", 64'(m0_ACK_O), 64'd0);

    // m1 releases while m0 asks, then m1 asks again: a tie in IDLE with last=1.
    step();
    s_ACK_I = 1'b0;
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'h400);
    step();
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h500);
    step(); sample();
    checkOutput("tie_repeat_m0", 64'(grant), 64'd1);
    checkOutput("tie_repeat_adr", 64'(s_ADR_O), 64'h400);
    step();
    applyStimulus(0, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0);
    step(); sample();
    checkOutput("both_idle", 64'(grant), 64'd0);

    // Watchdog: m1 strobes, slave never acks; error on the 4th strobe cycle.
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h600);
    for (int c = 1; c <= 4; c++) begin
      step(); sample();
      if (c < 4) begin
        checkOutput("to_no_err", 64'(m1_ERR_O), 64'd0);
        checkOutput("to_cyc_live", 64'(s_CYC_O), 64'd1);
      end else begin
        checkOutput("to_err_pulse", 64'(m1_ERR_O), 64'd1);
        checkOutput("to_err_m0", 64'(m0_ERR_O), 64'd0);
        checkOutput("to_cyc_cut", 64'(s_CYC_O), 64'd0);
        checkOutput("to_stb_cut", 64'(s_STB_O), 64'd0);
      end
    end
    step(); sample();
    checkOutput("errw_grant", 64'(grant), 64'd2);
    checkOutput("errw_cyc", 64'(s_CYC_O), 64'd0);
    checkOutput("errw_err_once", 64'(m1_ERR_O), 64'd0);
    step();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0);
    step(); sample();
    checkOutput("errw_exit", 64'(grant), 64'd0);

    // Ack landing exactly on the expiry cycle wins over the error.
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h700);
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 4) begin
        s_ACK_I = 1'b1;
        expectAck(1'b1, 32'h700);
      end
      sample();
      if (c == 4) begin
        checkOutput("race_no_err", 64'(m1_ERR_O), 64'd0);
        checkOutput("race_cyc_kept", 64'(s_CYC_O), 64'd1);
      end
    end
    step();
    s_ACK_I = 1'b0;
    sample();
    checkOutput("race_still_granted", 64'(grant), 64'd2);
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0);
    step(); sample();
    checkOutput("race_release", 64'(grant), 64'd0);

    // Asynchronous reset in the middle of a GNT1 cycle.
    applyStimulus(1, 1'b1, 1'b1, 1'b0, 32'h800);
    step(); sample();
    checkOutput("pre_rst_grant", 64'(grant), 64'd2);
    checkOutput("pre_rst_stb", 64'(s_STB_O), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_cyc", 64'(s_CYC_O), 64'd0);
    checkOutput("async_rst_stb", 64'(s_STB_O), 64'd0);
    checkOutput("async_rst_grant", 64'(grant), 64'd0);
    step();
    step();
    reset = 1'b1;
    sample();
    checkOutput("restart_idle", 64'(grant), 64'd0);
    step(); sample();
    checkOutput("restart_grant", 64'(grant), 64'd2);
    checkOutput("restart_adr", 64'(s_ADR_O), 64'h800);
    step();
    applyStimulus(1, 1'b0, 1'b0, 1'b0, '0);
    step(); step();

    checkOutput("sb_empty", 64'(expQueue.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
